// File: rtl/xoodyak_cmd_sequencer.sv
// Table-driven opmode/data sequencer feeding a Xoodyak core from a small command RAM.
// Define XOODYAK_SEQ_CHECK_EN to add per-entry expected-result checking of textout.
module xoodyak_cmd_sequencer #(
  parameter int DEPTH    = 16,
  parameter int DATA_W   = 352,
  parameter int OPMODE_W = 5,
  parameter int HOLD_W   = 4,
  parameter int TEXT_W   = 192,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                eph1,
  input  logic                reset_n,
  input  logic                prog_we,
  input  logic [AW-1:0]       prog_addr,
  input  logic [OPMODE_W-1:0] prog_opmode,
  input  logic [DATA_W-1:0]   prog_data,
  input  logic [HOLD_W-1:0]   prog_hold,
  input  logic                prog_last,
  input  logic                start,
  input  logic                abort,
  input  logic                loop_en,
  output logic [OPMODE_W-1:0] cmd_opmode,
  output logic [DATA_W-1:0]   cmd_data,
  output logic [AW-1:0]       cmd_idx,
  output logic                busy,
  output logic                done,
`ifdef XOODYAK_SEQ_CHECK_EN
  input  logic [TEXT_W-1:0]   prog_expect,
  input  logic                prog_chk,
  output logic [7:0]          mismatch_cnt,
  output logic [AW-1:0]       first_fail_idx,
`endif
  input  logic [TEXT_W-1:0]   textout,
  input  logic                textout_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [AW-1:0] IDX_MAX = AW'(DEPTH - 1);

  // Command table: intentionally not reset.
  logic [OPMODE_W-1:0] op_tab   [DEPTH];
  logic [DATA_W-1:0]   data_tab [DEPTH];
  logic [HOLD_W-1:0]   hold_tab [DEPTH];
  logic                last_tab [DEPTH];

  state_e              state_q;
  logic [AW-1:0]       idx_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic                busy_q, done_q;
  logic [OPMODE_W-1:0] op_q;
  logic [DATA_W-1:0]   data_q;

  logic                cur_last, expire;
  logic [AW-1:0]       nxt_idx;

  function automatic logic [HOLD_W-1:0] eff_hold(input logic [HOLD_W-1:0] h);
    return (h == '0) ? HOLD_W'(1) : h;
  endfunction

  always_ff @(posedge eph1) begin
    if (reset_n && prog_we && state_q == IDLE) begin
      op_tab[prog_addr]   <= prog_opmode;
      data_tab[prog_addr] <= prog_data;
      hold_tab[prog_addr] <= prog_hold;
      last_tab[prog_addr] <= prog_last;
    end
  end

  always_comb begin
    cur_last = last_tab[idx_q] || (idx_q == IDX_MAX);
    expire   = (hold_cnt_q <= HOLD_W'(1));
    nxt_idx  = cur_last ? '0 : idx_q + AW'(1);
  end

  // Outputs are loaded from the table on the same edge that moves the index,
  // so cmd_opmode/cmd_data always correspond to cmd_idx while busy.
  always_ff @(posedge eph1) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      op_q       <= '0;
      data_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && !abort) begin
            state_q    <= RUN;
            idx_q      <= '0;
            hold_cnt_q <= eff_hold(hold_tab[0]);
            busy_q     <= 1'b1;
            op_q       <= op_tab[0];
            data_q     <= data_tab[0];
          end
        end
        RUN: begin
          if (abort) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            hold_cnt_q <= '0;
            busy_q     <= 1'b0;
            op_q       <= '0;
            data_q     <= '0;
          end else if (expire) begin
            if (cur_last && !loop_en) begin
              state_q    <= DONE;
              hold_cnt_q <= '0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              op_q       <= '0;
              data_q     <= '0;
            end else begin
              idx_q      <= nxt_idx;
              hold_cnt_q <= eff_hold(hold_tab[nxt_idx]);
              op_q       <= op_tab[nxt_idx];
              data_q     <= data_tab[nxt_idx];
            end
          end else begin
            hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          idx_q   <= '0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_opmode = op_q;
  assign cmd_data   = data_q;
  assign cmd_idx    = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef XOODYAK_SEQ_CHECK_EN
  logic [TEXT_W-1:0] exp_tab [DEPTH];
  logic              chk_tab [DEPTH];
  logic [7:0]        mm_cnt_q;
  logic [AW-1:0]     ff_idx_q;

  always_ff @(posedge eph1) begin
    if (reset_n && prog_we && state_q == IDLE) begin
      exp_tab[prog_addr] <= prog_expect;
      chk_tab[prog_addr] <= prog_chk;
    end
  end

  // A zero count means no failure yet since start; the count saturates so it never wraps back.
  always_ff @(posedge eph1) begin
    if (!reset_n) begin
      mm_cnt_q <= '0;
      ff_idx_q <= '0;
    end else if (state_q == IDLE && start && !abort) begin
      mm_cnt_q <= '0;
      ff_idx_q <= '0;
    end else if (state_q == RUN && textout_valid && chk_tab[idx_q] &&
                 textout != exp_tab[idx_q]) begin
      if (mm_cnt_q != 8'hFF) mm_cnt_q <= mm_cnt_q + 8'd1;
      if (mm_cnt_q == 8'd0)  ff_idx_q <= idx_q;
    end
  end

  assign mismatch_cnt   = mm_cnt_q;
  assign first_fail_idx = ff_idx_q;
`else
  logic unused_textout;
  assign unused_textout = ^{textout, textout_valid};
`endif

endmodule

// File: tb/tb_xoodyak_cmd_sequencer.sv
// Self-checking bench for xoodyak_cmd_sequencer: vector table of hold patterns plus
// hand-written abort/loop/reset sequences, with a per-cycle opmode/index scoreboard.
module tb_xoodyak_cmd_sequencer;
  localparam int DEPTH = 16, DATA_W = 352, OPMODE_W = 5, HOLD_W = 4, TEXT_W = 192, AW = 4;

  logic                eph1 = 1'b0;
  logic                reset_n, prog_we, prog_last, start, abort, loop_en, textout_valid;
  logic [AW-1:0]       prog_addr;
  logic [OPMODE_W-1:0] prog_opmode;
  logic [DATA_W-1:0]   prog_data;
  logic [HOLD_W-1:0]   prog_hold;
  logic [TEXT_W-1:0]   textout;
  logic [OPMODE_W-1:0] cmd_opmode;
  logic [DATA_W-1:0]   cmd_data;
  logic [AW-1:0]       cmd_idx;
  logic                busy, done;
`ifdef XOODYAK_SEQ_CHECK_EN
  logic [TEXT_W-1:0]   prog_expect;
  logic                prog_chk;
  logic [7:0]          mismatch_cnt;
  logic [AW-1:0]       first_fail_idx;
`endif

  xoodyak_cmd_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .OPMODE_W(OPMODE_W),
                          .HOLD_W(HOLD_W), .TEXT_W(TEXT_W)) dut (
    .eph1(eph1), .reset_n(reset_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_opmode(prog_opmode), .prog_data(prog_data), .prog_hold(prog_hold),
    .prog_last(prog_last), .start(start), .abort(abort), .loop_en(loop_en),
    .cmd_opmode(cmd_opmode), .cmd_data(cmd_data), .cmd_idx(cmd_idx), .busy(busy),
    .done(done),
`ifdef XOODYAK_SEQ_CHECK_EN
    .prog_expect(prog_expect), .prog_chk(prog_chk), .mismatch_cnt(mismatch_cnt),
    .first_fail_idx(first_fail_idx),
`endif
    .textout(textout), .textout_valid(textout_valid));

  always #5 eph1 = ~eph1;

  typedef struct { logic [OPMODE_W-1:0] op; logic [AW-1:0] idx; } exp_t;
  typedef struct { logic [HOLD_W-1:0] h0, h1, h2; int len; } vec_t;

  exp_t                sb[$];
  vec_t                vt[4];
  logic [OPMODE_W-1:0] sh_op[DEPTH];
  logic [HOLD_W-1:0]   sh_hold[DEPTH];
  logic                sh_last[DEPTH];
  int                  n_chk = 0, n_err = 0;

  function automatic logic [DATA_W-1:0] data_of(int i);
    return {11{32'hD00D_0000 + 32'(i)}};
  endfunction

  task automatic chk(string nm, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge eph1);
    #1;
  endtask

  task automatic prog(int a, logic [OPMODE_W-1:0] op, logic [HOLD_W-1:0] h, logic l);
    prog_we = 1'b1; prog_addr = AW'(a); prog_opmode = op;
    prog_data = data_of(a); prog_hold = h; prog_last = l;
    step();
    prog_we = 1'b0;
    sh_op[a] = op; sh_hold[a] = h; sh_last[a] = l;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Expected per-cycle (opmode, index) stream built from the shadow table.
  task automatic load_model();
    sb.delete();
    for (int i = 0; i < DEPTH; i++) begin
      int n;
      n = (sh_hold[i] == 0) ? 1 : int'(sh_hold[i]);
      repeat (n) sb.push_back('{sh_op[i], AW'(i)});
      if (sh_last[i] || i == DEPTH - 1) break;
    end
  endtask

  task automatic drain(string nm, output int cyc);
    cyc = 0;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({nm, " op"}, cmd_opmode, e.op);
      chk({nm, " idx"}, cmd_idx, e.idx);
      chk({nm, " data"}, cmd_data, data_of(e.idx));
      chk({nm, " busy/done"}, {busy, done}, 2'b10);
      if (busy) cyc++;
      step();
    end
  endtask

  task automatic expect_done(string nm);
    chk({nm, " done pulse"}, {busy, done}, 2'b01);
    chk({nm, " done op"}, cmd_opmode, 0);
    step();
    chk({nm, " after done"}, {busy, done}, 2'b00);
  endtask

  task automatic prog_basic();
    prog(0, 5'h10, 4'd4, 1'b0);
    prog(1, 5'h11, 4'd4, 1'b0);
    prog(2, 5'h16, 4'd2, 1'b1);
  endtask

  initial begin
    int cyc, seen;
    reset_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_opmode = '0; prog_data = '0;
    prog_hold = '0; prog_last = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    textout = '0; textout_valid = 1'b0;
`ifdef XOODYAK_SEQ_CHECK_EN
    prog_expect = '0; prog_chk = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin sh_op[i] = '0; sh_hold[i] = '0; sh_last[i] = 1'b0; end
    vt[0] = '{4'd4, 4'd4, 4'd2, 10};
    vt[1] = '{4'd0, 4'd0, 4'd0, 3};
    vt[2] = '{4'd1, 4'd3, 4'd0, 5};
    vt[3] = '{4'd15, 4'd0, 4'd2, 18};

    start = 1'b1;
    step(); step();
    start = 1'b0;
    chk("reset busy/done", {busy, done}, 2'b00);
    chk("reset op", cmd_opmode, 0);
    chk("reset data", cmd_data, 0);
    chk("reset idx", cmd_idx, 0);
    reset_n = 1'b1;
    step();

    for (int v = 0; v < 4; v++) begin
      prog(0, 5'h10, vt[v].h0, 1'b0);
      prog(1, 5'h11, vt[v].h1, 1'b0);
      prog(2, 5'h16, vt[v].h2, 1'b1);
      load_model();
      do_start();
      drain($sformatf("vec%0d", v), cyc);
      chk($sformatf("vec%0d length", v), cyc, vt[v].len);
      expect_done($sformatf("vec%0d", v));
    end

    prog_basic();
    loop_en = 1'b1;
    load_model();
    do_start();
    drain("loop", cyc);
    chk("loop wrap op", cmd_opmode, 5'h10);
    chk("loop wrap idx", cmd_idx, 0);
    chk("loop wrap busy/done", {busy, done}, 2'b10);
    abort = 1'b1;
    step();
    abort = 1'b0; loop_en = 1'b0;
    chk("loop abort op", cmd_opmode, 0);
    chk("loop abort busy/done", {busy, done}, 2'b00);

    for (int i = 0; i < DEPTH; i++) prog(i, 5'(i + 1), 4'd0, 1'b0);
    load_model();
    do_start();
    drain("all16", cyc);
    chk("all16 length", cyc, 16);
    expect_done("all16");

    prog_basic();
    do_start();
    repeat (5) step();
    chk("abort point idx", cmd_idx, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort op", cmd_opmode, 0);
    chk("abort busy/done", {busy, done}, 2'b00);
    seen = 0;
    repeat (15) begin step(); if (done) seen++; end
    chk("abort no done", seen, 0);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start+abort busy", busy, 0);
    step();
    chk("start+abort stays idle", busy, 0);

    do_start();
    step();
    prog_we = 1'b1; prog_addr = 4'd1; prog_opmode = 5'h1f;
    prog_data = data_of(99); prog_hold = 4'd7; prog_last = 1'b1;
    step();
    prog_we = 1'b0;
    for (int k = 0; k < 30 && !done; k++) step();
    chk("run-write done seen", done, 1);
    step();
    load_model();
    do_start();
    drain("rerun", cyc);
    expect_done("rerun");

    do_start();
    step(); step();
    reset_n = 1'b0; start = 1'b1; abort = 1'b1; prog_we = 1'b1;
    step();
    start = 1'b0; abort = 1'b0; prog_we = 1'b0;
    chk("midrun reset op", cmd_opmode, 0);
    chk("midrun reset data", cmd_data, 0);
    chk("midrun reset idx", cmd_idx, 0);
    chk("midrun reset busy/done", {busy, done}, 2'b00);
    reset_n = 1'b1;
    step();
    chk("post reset idle", {busy, done}, 2'b00);

`ifdef XOODYAK_SEQ_CHECK_EN
    for (int i = 0; i < 4; i++) prog(i, 5'(i + 1), 4'd1, 1'b0);
    prog_expect = 192'h87a0_3c5e_1b92_44d0_6f18_a7c3_95e2_d147_0a5b_8c3e_6f21_0e30;
    prog_chk = 1'b1;
    prog(4, 5'h15, 4'd15, 1'b1);
    prog_chk = 1'b0;
    do_start();
    chk("chk cleared", mismatch_cnt, 0);
    repeat (4) step();
    chk("chk idx", cmd_idx, 4);
    textout = 192'hbb44_1c9d_7a03_e5f2_4b86_0c1d_93aa_57e0_2f6b_c814_7d09_de1e;
    textout_valid = 1'b1;
    step();
    textout_valid = 1'b0;
    chk("chk one mismatch", mismatch_cnt, 1);
    chk("chk first idx", first_fail_idx, 4);
    loop_en = 1'b1; textout_valid = 1'b1;
    repeat (400) step();
    chk("chk saturate", mismatch_cnt, 255);
    chk("chk first idx held", first_fail_idx, 4);
    textout_valid = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0; loop_en = 1'b0;
    do_start();
    chk("chk start clears", mismatch_cnt, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
